// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-bank arbiter: state encoding,
// default parameters and a one-hot helper.
package reg_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 8;
   localparam int DEF_AW    = 3;
   localparam int MAX_REQ   = 8;

   function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
      logic [MAX_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after i_ptr, wrapping from N_REQ-1 back to 0.
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic [IW-1:0]    o_idx,
   output logic             o_valid
);

   always_comb begin
      logic [IW-1:0] j;
      o_valid = 1'b0;
      o_idx   = '0;
      j       = '0;
      // Scan from farthest to nearest so the nearest set bit wins last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = IW'((int'(i_ptr) + k) % N_REQ);
         if (i_req[j]) begin
            o_valid = 1'b1;
            o_idx   = j;
         end
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter owning a flip-flop register bank: grant cycle then
// write cycle per request, plus a registered read port.
// Optional burst locking is enabled by defining REG_ARB_LOCK_EN.
module reg_bank_arbiter
   import reg_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [N_REQ-1:0]       i_req,
   input  logic [N_REQ*AW-1:0]    i_wr_addr,
   input  logic [N_REQ*WIDTH-1:0] i_wr_data,
`ifdef REG_ARB_LOCK_EN
   input  logic [N_REQ-1:0]       i_lock,
`endif
   output logic [N_REQ-1:0]       o_gnt,
   output logic [N_REQ-1:0]       o_ack,
   output logic                   o_busy,
   input  logic [AW-1:0]          i_rd_addr,
   output logic [WIDTH-1:0]       o_rd_data
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           r_state, w_state_nx;
   logic [IW-1:0]    r_w, w_w_nx;
   logic [IW-1:0]    r_rr_ptr, w_ptr_nx, w_ptr_inc;
   logic [N_REQ-1:0] r_gnt, w_gnt_nx, w_ack;
   logic             w_we;
   logic [IW-1:0]    w_pick_idx, w_sel_idx;
   logic             w_pick_valid, w_sel_valid;
   logic [AW-1:0]    w_wr_addr;
   logic [WIDTH-1:0] w_wr_data;
   logic [WIDTH-1:0] r_bank [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

`ifdef REG_ARB_LOCK_EN
   logic             r_lock_on, w_lock_on_nx;
   logic [IW-1:0]    r_lock_idx, w_lock_idx_nx;
`endif

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr_pick (
      .i_req   (i_req),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   assign w_wr_addr = i_wr_addr[int'(r_w)*AW +: AW];
   assign w_wr_data = i_wr_data[int'(r_w)*WIDTH +: WIDTH];
   assign w_ptr_inc = (r_w == IW'(N_REQ - 1)) ? '0 : r_w + 1'b1;

   always_comb begin
      w_state_nx  = r_state;
      w_w_nx      = r_w;
      w_ptr_nx    = r_rr_ptr;
      w_gnt_nx    = '0;
      w_ack       = '0;
      w_we        = 1'b0;
      w_sel_valid = w_pick_valid;
      w_sel_idx   = w_pick_idx;
`ifdef REG_ARB_LOCK_EN
      w_lock_on_nx  = r_lock_on;
      w_lock_idx_nx = r_lock_idx;
      // A held lock makes its owner the only candidate; dropping req frees it.
      if (r_state == IDLE && r_lock_on) begin
         if (i_req[r_lock_idx]) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = r_lock_idx;
         end else begin
            w_lock_on_nx = 1'b0;
         end
      end
`endif
      case (r_state)
         IDLE: begin
            if (w_sel_valid) begin
               w_state_nx = GRANT;
               w_w_nx     = w_sel_idx;
               w_gnt_nx   = N_REQ'(onehot(3'(w_sel_idx)));
            end
         end
         GRANT: begin
            w_state_nx = IDLE;
            if (i_req[r_w]) begin
               w_ack = N_REQ'(onehot(3'(r_w)));
               w_we  = 1'b1;
`ifdef REG_ARB_LOCK_EN
               w_lock_on_nx  = i_lock[r_w];
               w_lock_idx_nx = r_w;
               w_ptr_nx      = i_lock[r_w] ? r_rr_ptr : w_ptr_inc;
`else
               w_ptr_nx = w_ptr_inc;
`endif
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_w       <= '0;
         r_rr_ptr  <= '0;
         r_gnt     <= '0;
         r_rd_data <= '0;
         for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
`ifdef REG_ARB_LOCK_EN
         r_lock_on  <= 1'b0;
         r_lock_idx <= '0;
`endif
      end else begin
         r_state   <= w_state_nx;
         r_w       <= w_w_nx;
         r_rr_ptr  <= w_ptr_nx;
         r_gnt     <= w_gnt_nx;
         r_rd_data <= r_bank[i_rd_addr];
         if (w_we) r_bank[w_wr_addr] <= w_wr_data;
`ifdef REG_ARB_LOCK_EN
         r_lock_on  <= w_lock_on_nx;
         r_lock_idx <= w_lock_idx_nx;
`endif
      end
   end

   // A reset edge aborts the pending write, so its ack must not be shown.
   assign o_ack     = i_reset ? '0 : w_ack;
   assign o_gnt     = r_gnt;
   assign o_busy    = (r_state == GRANT);
   assign o_rd_data = r_rd_data;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed scenarios then random
// traffic, all compared each cycle against a transaction-level model.
module tb_reg_bank_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int D  = 8;
   localparam int AW = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N*AW-1:0] wr_addr;
   logic [N*W-1:0] wr_data;
`ifdef REG_ARB_LOCK_EN
   logic [N-1:0]   lock;
`endif
   logic [N-1:0]   gnt, ack;
   logic           busy;
   logic [AW-1:0]  rd_addr;
   logic [W-1:0]   rd_data;

   reg_bank_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D), .AW(AW)) dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_req     (req),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
`ifdef REG_ARB_LOCK_EN
      .i_lock    (lock),
`endif
      .o_gnt     (gnt),
      .o_ack     (ack),
      .o_busy    (busy),
      .i_rd_addr (rd_addr),
      .o_rd_data (rd_data)
   );

   always #5 clk = ~clk;

   // Reference model: pending winner, pointer, lock owner, storage, read reg.
   int m_busy, m_w, m_ptr, m_rd, m_lock_on, m_lock_idx;
   int m_bank [D];

   int n_checks = 0;
   int n_fail   = 0;
   int tick_no  = 0;
   bit capture  = 1'b0;
   int ack_q [$];
   int ack_t [$];
   logic [N-1:0] last_ack;

   function automatic int lock_bit(int i);
`ifdef REG_ARB_LOCK_EN
      return int'(lock[i]);
`else
      return i - i;
`endif
   endfunction

   function automatic int rr_find(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int old_rd;
      int win;
      if (reset) begin
         m_busy = 0; m_w = 0; m_ptr = 0; m_rd = 0; m_lock_on = 0; m_lock_idx = 0;
         for (int i = 0; i < D; i++) m_bank[i] = 0;
         return;
      end
      old_rd = m_bank[rd_addr];
      if (m_busy != 0) begin
         if (req[m_w]) begin
            m_bank[wr_addr[m_w*AW +: AW]] = int'(wr_data[m_w*W +: W]);
            if (lock_bit(m_w) != 0) begin
               m_lock_on  = 1;
               m_lock_idx = m_w;
            end else begin
               m_lock_on = 0;
               m_ptr     = (m_w + 1) % N;
            end
         end
         m_busy = 0;
      end else begin
         win = -1;
         if (m_lock_on != 0) begin
            if (req[m_lock_idx]) win = m_lock_idx;
            else m_lock_on = 0;
         end
         if (win < 0) win = rr_find(req, m_ptr);
         if (win >= 0) begin
            m_busy = 1;
            m_w    = win;
         end
      end
      m_rd = old_rd;
   endtask

   task automatic tick();
      int exp_gnt, exp_ack;
      @(negedge clk);
      exp_gnt = (m_busy != 0) ? (1 << m_w) : 0;
      exp_ack = (m_busy != 0 && req[m_w] && !reset) ? (1 << m_w) : 0;
      chk("gnt", 32'(gnt), exp_gnt);
      chk("ack", 32'(ack), exp_ack);
      chk("busy", 32'(busy), m_busy);
      chk("rd_data", 32'(rd_data), m_rd);
      if (capture && ack != '0) begin
         for (int i = 0; i < N; i++) if (ack[i]) ack_q.push_back(i);
         ack_t.push_back(tick_no);
      end
      last_ack = ack;
      model_step();
      @(posedge clk);
      #1;
      tick_no++;
   endtask

   task automatic set_wr(int i, int a, int d);
      wr_addr[i*AW +: AW] = AW'(a);
      wr_data[i*W +: W]   = W'(d);
   endtask

   task automatic rand_drive();
      for (int i = 0; i < N; i++) begin
         if (req[i] && last_ack[i]) begin
            if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
            else set_wr(i, $urandom_range(D-1, 0), $urandom_range(255, 0));
         end else if (req[i]) begin
            if ($urandom_range(99, 0) < 3) req[i] = 1'b0;
         end else if ($urandom_range(99, 0) < 30) begin
            req[i] = 1'b1;
            set_wr(i, $urandom_range(D-1, 0), $urandom_range(255, 0));
         end
      end
`ifdef REG_ARB_LOCK_EN
      lock = N'($urandom_range(15, 0) & $urandom_range(15, 0));
`endif
      rd_addr = AW'($urandom_range(D-1, 0));
      reset   = ($urandom_range(499, 0) == 0);
   endtask

   initial begin
      int fair_exp [5];
      fair_exp = '{0, 1, 2, 3, 0};
      reset = 1'b1; req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0; last_ack = '0;
`ifdef REG_ARB_LOCK_EN
      lock = '0;
`endif
      @(posedge clk); #1;
      model_step();
      tick();
      reset = 1'b0;
      for (int a = 0; a < D; a++) begin
         rd_addr = AW'(a);
         tick();
      end
      tick();

      // single write
      set_wr(0, 3, 'hA5); req = 4'b0001;
      tick();
      chk("single_gnt", 32'(gnt), 32'h1);
      tick();
      req = '0; rd_addr = 3;
      tick();
      chk("single_rd", 32'(rd_data), 32'hA5);

      // fairness from a fresh pointer
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < N; i++) set_wr(i, i, 'h10 + i);
      req = 4'b1111;
      ack_q.delete(); ack_t.delete(); capture = 1'b1;
      repeat (10) tick();
      capture = 1'b0; req = '0;
      tick();
      chk("fair_count", ack_q.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < ack_q.size()) chk("fair_order", ack_q[i], fair_exp[i]);
      for (int i = 1; i < ack_t.size(); i++)
         chk("fair_spacing", ack_t[i] - ack_t[i-1], 2);

      // withdrawal keeps the pointer at the withdrawn requester
      reset = 1'b1; tick(); reset = 1'b0;
      set_wr(1, 2, 'h5A); req = 4'b0010;
      tick(); tick();
      req = '0; rd_addr = 4;
      tick();
      set_wr(2, 4, 'hC3); req = 4'b0100;
      tick();
      chk("wd_gnt", 32'(gnt), 32'h4);
      req = '0;
      tick();
      set_wr(0, 0, 'h01); set_wr(1, 1, 'h02); set_wr(3, 7, 'h03);
      req = 4'b1111;
      tick();
      chk("wd_regrant", 32'(gnt), 32'h4);
      chk("wd_bank", 32'(rd_data), 32'h0);
      req = 4'b0100;
      tick();
      req = '0;
      tick();

      // read-before-write collision
      reset = 1'b1; tick(); reset = 1'b0;
      rd_addr = 5; set_wr(3, 5, 'h11); req = 4'b1000;
      tick(); tick();
      req = '0;
      tick();
      set_wr(3, 5, 'h3C); req = 4'b1000;
      tick(); tick();
      chk("coll_old", 32'(rd_data), 32'h11);
      req = '0;
      tick();
      chk("coll_new", 32'(rd_data), 32'h3C);

      // reset during grant aborts the write
      set_wr(2, 6, 'h77); req = 4'b0100;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; req = '0;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rd_addr = 6;
      tick(); tick();
      chk("rst_bank", 32'(rd_data), 32'h0);
      req = 4'b1111;
      tick();
      chk("rst_ptr", 32'(gnt), 32'h1);
      tick();
      req = '0;
      tick();

`ifdef REG_ARB_LOCK_EN
      reset = 1'b1; tick(); reset = 1'b0;
      set_wr(0, 1, 'hAA); set_wr(1, 2, 'hBB);
      req = 4'b0011; lock = 4'b0010;
      ack_q.delete(); ack_t.delete(); capture = 1'b1;
      repeat (8) tick();
      capture = 1'b0;
      chk("lock_count", ack_q.size(), 4);
      if (ack_q.size() >= 4) begin
         chk("lock_0", ack_q[0], 0);
         chk("lock_1", ack_q[1], 1);
         chk("lock_2", ack_q[2], 1);
         chk("lock_3", ack_q[3], 1);
      end
      lock = '0;
      repeat (4) tick();
      req = '0;
      tick();
`endif

      // random traffic
      reset = 1'b1; tick(); reset = 1'b0;
      repeat (3000) begin
         rand_drive();
         tick();
      end
      reset = 1'b0; req = '0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
